// File: rtl/cpu_perf_monitor_pkg.sv
// Shared encodings for the CPU performance monitor: FSM states, counter
// select codes, termination reasons and the instruction decode constants.
package cpu_perf_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] REASON_NONE   = 2'd0;
    localparam logic [1:0] REASON_BUDGET = 2'd1;
    localparam logic [1:0] REASON_HANG   = 2'd2;

    localparam int NUM_CNT = 8;

    localparam logic [2:0] SEL_CYCLE = 3'd0;
    localparam logic [2:0] SEL_INSTR = 3'd1;
    localparam logic [2:0] SEL_ADDI  = 3'd2;
    localparam logic [2:0] SEL_ADD   = 3'd3;
    localparam logic [2:0] SEL_LW    = 3'd4;
    localparam logic [2:0] SEL_BEQ   = 3'd5;
    localparam logic [2:0] SEL_STALL = 3'd6;
    localparam logic [2:0] SEL_FLUSH = 3'd7;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

endpackage

// File: rtl/cpu_perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cpu_perf_monitor.sv
// Performance and liveness monitor beside the 5-stage CPU: event counters,
// periodic PC/instruction snapshots and budget/hang run termination.
module cpu_perf_monitor
    import cpu_perf_monitor_pkg::*;
#(
    parameter int ADDR_LEN      = 32,
    parameter int DATA_LEN      = 32,
    parameter int CNT_W         = 32,
    parameter int SAMPLE_PERIOD = 10,
    parameter int MAX_CYCLES    = 50,
    parameter int HANG_LIMIT    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] pc,
    input  logic [DATA_LEN-1:0] inst,
    input  logic                inst_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic [2:0]          rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic                snap_valid,
    output logic [ADDR_LEN-1:0] snap_pc,
    output logic [DATA_LEN-1:0] snap_inst,
    output logic                running,
    output logic                done,
    output logic [1:0]          done_reason
);

    // The budget tracker is separate from cycle_cnt so a narrow, saturated
    // cycle_cnt can never prevent the run from ending.
    localparam int BUD_W  = $clog2(MAX_CYCLES + 1);
    localparam int HANG_W = $clog2(HANG_LIMIT + 1);
    localparam int SAMP_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [BUD_W-1:0]  BUD_LAST    = BUD_W'(MAX_CYCLES - 1);
    localparam logic [HANG_W-1:0] HANG_LAST   = HANG_W'(HANG_LIMIT - 1);
    localparam logic [SAMP_W-1:0] SAMP_RELOAD = SAMP_W'(SAMPLE_PERIOD - 1);

    state_e              state_q, state_d;
    logic [1:0]          reason_q, reason_d;
    logic [BUD_W-1:0]    budget_q, budget_d;
    logic [HANG_W-1:0]   hang_q, hang_d;
    logic [SAMP_W-1:0]   samp_q, samp_d;
    logic [ADDR_LEN-1:0] prev_pc_q;
    logic [ADDR_LEN-1:0] snap_pc_q, snap_pc_d;
    logic [DATA_LEN-1:0] snap_inst_q, snap_inst_d;
    logic                snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0]    rd_data_q, rd_data_d;

    logic             run, clr, qual, hang_reset, budget_hit, hang_hit, snap_take;
    logic [5:0]       opcode, funct;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0] cnt [NUM_CNT];

    assign run        = (state_q == ST_RUN);
    assign qual       = inst_valid && !stall && !flush;
    assign opcode     = inst[31:26];
    assign funct      = inst[5:0];
    assign hang_reset = (pc != prev_pc_q) || stall || flush;
    assign budget_hit = run && (budget_q == BUD_LAST);
    assign hang_hit   = run && !hang_reset && (hang_q == HANG_LAST);
    assign snap_take  = run && (samp_q == '0);

    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        clr      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (budget_hit) begin
                    state_d  = ST_DONE;
                    reason_d = REASON_BUDGET;
                end else if (hang_hit) begin
                    state_d  = ST_DONE;
                    reason_d = REASON_HANG;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    reason_d = REASON_NONE;
                    clr      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run trackers idle at zero outside RUN so cycle 0 always snapshots.
    always_comb begin
        budget_d     = '0;
        hang_d       = '0;
        samp_d       = '0;
        snap_valid_d = snap_take;
        snap_pc_d    = snap_pc_q;
        snap_inst_d  = snap_inst_q;
        if (run) begin
            budget_d = budget_q + BUD_W'(1);
            hang_d   = hang_reset ? '0 : hang_q + HANG_W'(1);
            samp_d   = (samp_q == '0) ? SAMP_RELOAD : samp_q - SAMP_W'(1);
        end
        if (clr) begin
            snap_pc_d   = '0;
            snap_inst_d = '0;
        end else if (snap_take) begin
            snap_pc_d   = pc;
            snap_inst_d = inst;
        end
    end

    always_comb begin
        inc            = '0;
        inc[SEL_CYCLE] = run;
        inc[SEL_INSTR] = run && qual;
        inc[SEL_ADDI]  = run && qual && (opcode == OP_ADDI);
        inc[SEL_ADD]   = run && qual && (opcode == OP_R_TYPE) && (funct == FUNCT_ADD);
        inc[SEL_LW]    = run && qual && (opcode == OP_LW);
        inc[SEL_BEQ]   = run && qual && (opcode == OP_BEQ);
        inc[SEL_STALL] = run && stall;
        inc[SEL_FLUSH] = run && flush;
        rd_data_d      = cnt[rd_sel];
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (inc[g]),
            .cnt   (cnt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            reason_q     <= REASON_NONE;
            budget_q     <= '0;
            hang_q       <= '0;
            samp_q       <= '0;
            prev_pc_q    <= '0;
            snap_pc_q    <= '0;
            snap_inst_q  <= '0;
            snap_valid_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            reason_q     <= reason_d;
            budget_q     <= budget_d;
            hang_q       <= hang_d;
            samp_q       <= samp_d;
            prev_pc_q    <= pc;
            snap_pc_q    <= snap_pc_d;
            snap_inst_q  <= snap_inst_d;
            snap_valid_q <= snap_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign snap_valid  = snap_valid_q;
    assign snap_pc     = snap_pc_q;
    assign snap_inst   = snap_inst_q;
    assign running     = run;
    assign done        = (state_q == ST_DONE);
    assign done_reason = reason_q;

endmodule

// File: doc/cpu_perf_monitor.md
# cpu_perf_monitor

Synthesizable, parametrised performance and liveness monitor for the 5-stage pipelined CPU. Sits beside the core, samples the fetch-stage PC/instruction each cycle, and keeps saturating counters for cycles, retired-class instructions, stalls and flushes. It also produces periodic PC/instruction snapshots and detects run completion: cycle budget exhausted or PC hang. Counter values are read through a registered select port, so the testbench or a debug bus can poll without hierarchical references.

## Interface
Parameters:
- `ADDR_LEN`, default 32: PC width.
- `DATA_LEN`, default 32: instruction width.
- `CNT_W`, default 32: width of every counter.
- `SAMPLE_PERIOD`, default 10: cycles between snapshots; must be ≥1.
- `MAX_CYCLES`, default 50: cycle budget; reaching it ends the run.
- `HANG_LIMIT`, default 8: consecutive cycles with unchanged PC, no stall and no flush that count as a hang; must be ≥2.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a run.
- `pc`, in, `ADDR_LEN`: fetch-stage PC.
- `inst`, in, `DATA_LEN`: fetch-stage instruction.
- `inst_valid`, in, 1: `inst` is real, not a bubble.
- `stall`, in, 1: the pipeline is stalled this cycle (load-use).
- `flush`, in, 1: IF/ID is flushed this cycle (taken branch).
- `rd_sel`, in, 3: counter select.
- `rd_data`, out, `CNT_W`: selected counter, registered.
- `snap_valid`, out, 1: one-cycle pulse when a snapshot is taken.
- `snap_pc`, out, `ADDR_LEN`: PC captured at the last snapshot.
- `snap_inst`, out, `DATA_LEN`: instruction captured at the last snapshot.
- `running`, out, 1: FSM is in RUN.
- `done`, out, 1: FSM is in DONE.
- `done_reason`, out, 2: 0 none, 1 budget exhausted, 2 hang.

## Operation
- FSM states IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when `cycle_cnt` reaches `MAX_CYCLES`, or when the hang counter reaches `HANG_LIMIT`.
  - DONE→RUN on `start`. Re-entering RUN clears all counters, snapshots and `done_reason`.
  - `start` while in RUN is ignored.
- Counters increment only in RUN. Each saturates at all-ones.
  - `cycle_cnt`: every RUN cycle.
  - `instr_cnt`: `inst_valid && !stall && !flush`.
  - `addi_cnt`, `add_cnt`, `lw_cnt`, `beq_cnt`: same qualifier plus opcode decode using `OP_ADDI`, `OP_R_TYPE` with `FUNCT_ADD`, `OP_LW`, `OP_BEQ` from defines.v.
  - `stall_cnt`: `stall`.
  - `flush_cnt`: `flush`.
  - If `stall` and `flush` are both high, both counters increment and no instruction is counted.
- `rd_sel` mapping: 0 cycle, 1 instr, 2 addi, 3 add, 4 lw, 5 beq, 6 stall, 7 flush. Reads are legal in any state; counters hold their values in DONE.
- Snapshot: in RUN, when `cycle_cnt % SAMPLE_PERIOD == 0` (including cycle 0), the current `pc` and `inst` are captured and `snap_valid` pulses. The modulo uses a separate down-counter, not a divider.
- Hang counter: resets to 0 whenever `pc` differs from the previous-cycle PC, or `stall` or `flush` is high; otherwise it increments.
- Priority on the terminating cycle: if budget and hang fire in the same cycle, `done_reason` is 1.

## Timing
- Reset (`rst_n` low at a rising edge): state IDLE; all counters, `rd_data`, `snap_pc`, `snap_inst` = 0; `snap_valid`, `running`, `done` = 0; `done_reason` = 0. A reset asserted mid-RUN aborts the run with no DONE.
- `start` sampled at edge N gives `running` = 1 after edge N. The first RUN cycle is cycle 0.
- The cycle in which `cycle_cnt` becomes `MAX_CYCLES` is the last counted cycle. `done` rises at the next edge, so exactly `MAX_CYCLES` RUN cycles are counted.
- `rd_data` latency is 1 cycle from `rd_sel`.
- `snap_valid` is registered and high for exactly one cycle, aligned with `snap_pc` and `snap_inst` being updated.

## Structure
- Shared package or defines: opcode and funct constants (already in defines.v), `rd_sel` encodings, `done_reason` encodings, FSM state encodings.
- One natural sub-module: `sat_counter` (parameter `CNT_W`; inputs `clr`, `inc`; output `cnt`), instantiated 8 times.

## Test plan
- Reset mid-run: `start`, run 5 cycles, drop `rst_n` for 1 cycle → all outputs 0, state IDLE, `running` = 0.
- Budget: `MAX_CYCLES` = 50, PC incrementing by 4 each cycle → `done` after 50 RUN cycles, `done_reason` = 1, `cycle_cnt` = 50. Snapshots occur at cycles 0, 10, 20, 30, 40 (5 pulses).
- Class counts: feed ADDI (0x20080005), ADD (0x01094020), LW (0x8D090000), BEQ (0x11090002), one each → `rd_sel` 1..5 read 4, 1, 1, 1, 1.
- Stall/flush: LW with `stall` = 1 for one cycle, then BEQ with `flush` = 1 → `stall_cnt` = 1, `flush_cnt` = 1. Instructions are not counted in the stalled or flushed cycles.
- Hang: PC held at 0x0000001C with `stall` = 0 → `done` after 8 unchanged cycles, `done_reason` = 2. Repeating with `stall` = 1 throughout → no hang.
- Saturation and restart: `CNT_W` = 4, `MAX_CYCLES` = 40 → `cycle_cnt` holds at 15. Then pulse `start` in DONE → all counters return to 0 and `running` = 1.
